// File: rtl/oit_adder_arbiter.sv
// Round-robin arbiter sharing one ripple adder among COUNT requesters.
// Flow per grant: LOAD captures operands, EXEC adds, RESP pulses done and re-arbitrates.

module oit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module oit_adder_arbiter #(
  parameter int COUNT = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COUNT-1:0]       req,
  input  logic [COUNT*WIDTH-1:0] a,
  input  logic [COUNT*WIDTH-1:0] b,
  output logic [COUNT-1:0]       grant,
  output logic [COUNT-1:0]       done,
  output logic [WIDTH:0]         sum,
  output logic                   busy
);
  localparam int IW = $clog2(COUNT);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

  state_t                        state_q, state_d;
  logic [COUNT-1:0]              grant_q, grant_d;
  logic [COUNT-1:0]              done_q, done_d;
  logic [WIDTH:0]                sum_q, sum_d;
  logic [IW-1:0]                 ptr_q, ptr_d;
  logic [IW-1:0]                 w_q, w_d;
  logic [WIDTH-1:0]              opa_q, opa_d;
  logic [WIDTH-1:0]              opb_q, opb_d;

  logic [COUNT-1:0][WIDTH-1:0]   a_v, b_v;
  logic [WIDTH:0]                carry;
  logic [WIDTH-1:0]              add_s;
  logic [COUNT-1:0]              arb_req;
  logic [IW-1:0]                 arb_ptr, arb_win, w_inc;
  logic                          arb_hit;
  int                            scan_idx;

  assign a_v = a;
  assign b_v = b;

  assign w_inc = (int'(w_q) == COUNT - 1) ? '0 : w_q + IW'(1);

  // Shared ripple-carry datapath, one full-adder cell per bit
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    oit_fa u_fa (
      .a  (opa_q[i]),
      .b  (opb_q[i]),
      .ci (carry[i]),
      .s  (add_s[i]),
      .co (carry[i+1])
    );
  end

  // In RESP the current owner is masked and the scan starts just past it
  always_comb begin
    arb_req  = req;
    arb_ptr  = ptr_q;
    if (state_q == RESP) begin
      arb_req[w_q] = 1'b0;
      arb_ptr      = w_inc;
    end
    arb_hit  = 1'b0;
    arb_win  = '0;
    scan_idx = 0;
    for (int k = 0; k < COUNT; k++) begin
      scan_idx = int'(arb_ptr) + k;
      if (scan_idx >= COUNT) scan_idx = scan_idx - COUNT;
      if (!arb_hit && arb_req[scan_idx[IW-1:0]]) begin
        arb_hit = 1'b1;
        arb_win = scan_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    sum_d   = sum_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          w_d     = arb_win;
          grant_d = COUNT'(1) << arb_win;
          state_d = LOAD;
        end
      end
      LOAD: begin
        opa_d   = a_v[w_q];
        opb_d   = b_v[w_q];
        state_d = EXEC;
      end
      EXEC: begin
        sum_d   = {carry[WIDTH], add_s};
        done_d  = COUNT'(1) << w_q;
        state_d = RESP;
      end
      RESP: begin
        ptr_d = w_inc;
        if (arb_hit) begin
          w_d     = arb_win;
          grant_d = COUNT'(1) << arb_win;
          state_d = LOAD;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      sum_q   <= '0;
      ptr_q   <= '0;
      w_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign busy  = (state_q != IDLE);

endmodule
